// File: rtl/dec_refill_pkg.sv
// Shared constants and state encoding for the AV1 entropy-decoder bitstream
// refill front end (dec_bit_refill) and its window shifter.
package dec_refill_pkg;

    localparam int D_WINDOW_WIDTH    = 32;
    localparam int D_CNT_WIDTH       = 6;
    localparam int D_SIZE            = 5;
    localparam int D_BITSTREAM_WIDTH = 8;
    localparam int D_MIN_VALID       = 16;
    localparam int D_MAX_SHIFT       = 16;

    // Vacant window bits are always ones (the encoder pads with ones).
    localparam logic [D_WINDOW_WIDTH-1:0] WINDOW_ONES = '1;

    localparam logic [D_CNT_WIDTH-1:0] CNT_FULL      = D_CNT_WIDTH'(D_WINDOW_WIDTH);
    localparam logic [D_CNT_WIDTH-1:0] CNT_MIN_VALID = D_CNT_WIDTH'(D_MIN_VALID);
    localparam logic [D_CNT_WIDTH-1:0] CNT_READY_MAX = D_CNT_WIDTH'(D_WINDOW_WIDTH - D_BITSTREAM_WIDTH);
    localparam logic [D_SIZE-1:0]      SHIFT_MAX     = D_SIZE'(D_MAX_SHIFT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2,
        ST_EOS  = 2'd3
    } state_t;

endpackage

// File: rtl/dec_window_shifter.sv
// Combinational dif-window update: shift left with ones shifted in, then
// XOR-insert one byte at offset c' = cnt - d. Stores ~byte because the
// vacant bits it lands on are ones. Caller guarantees d <= cnt and, when
// inserting, c' <= W-8.
module dec_window_shifter
    import dec_refill_pkg::*;
(
    input  logic [D_WINDOW_WIDTH-1:0]    window_i,
    input  logic [D_CNT_WIDTH-1:0]       cnt_i,
    input  logic                         shift_en_i,
    input  logic [D_SIZE-1:0]            shift_amt_i,
    input  logic                         insert_en_i,
    input  logic [D_BITSTREAM_WIDTH-1:0] byte_i,
    output logic [D_WINDOW_WIDTH-1:0]    window_o,
    output logic [D_CNT_WIDTH-1:0]       cnt_o
);

    logic [2*D_WINDOW_WIDTH-1:0] ext;
    logic [D_WINDOW_WIDTH-1:0]   shifted;
    logic [D_WINDOW_WIDTH-1:0]   ins_mask;
    logic [D_CNT_WIDTH-1:0]      amt;
    logic [D_CNT_WIDTH-1:0]      cnt_sh;

    // Shift first (ones enter from the bottom), then insert at the new count.
    always_comb begin
        amt      = shift_en_i ? D_CNT_WIDTH'(shift_amt_i) : '0;
        ext      = {window_i, WINDOW_ONES} << amt;
        shifted  = ext[2*D_WINDOW_WIDTH-1:D_WINDOW_WIDTH];
        cnt_sh   = cnt_i - amt;
        ins_mask = {byte_i, {(D_WINDOW_WIDTH-D_BITSTREAM_WIDTH){1'b0}}} >> cnt_sh;
        window_o = insert_en_i ? (shifted ^ ins_mask) : shifted;
        cnt_o    = insert_en_i ? (cnt_sh + D_CNT_WIDTH'(D_BITSTREAM_WIDTH)) : cnt_sh;
    end

endmodule

// File: rtl/dec_bit_refill.sv
// Bitstream refill front end for the AV1 entropy decoder. Accepts one byte
// per cycle and keeps a left-aligned, inverted dif window that the decoder
// core drains with normalization shifts.
// Optional build macro DEC_REFILL_BYTE_COUNT_EN adds out_byte_count.
//
// Handshake: a byte transfers on a rising clk edge where in_byte_valid and
// in_byte_ready are both high. in_byte_ready is decoded from registers only
// (state FILL/RUN and cnt <= W-8), so it never depends on in_shift_* or
// in_byte_valid in the same cycle.
module dec_bit_refill
    import dec_refill_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_flag_first,
    input  logic [D_BITSTREAM_WIDTH-1:0] in_byte,
    input  logic                         in_byte_valid,
    input  logic                         in_byte_last,
    output logic                         in_byte_ready,
    input  logic                         in_shift_valid,
    input  logic [D_SIZE-1:0]            in_shift_amount,
    output logic [D_WINDOW_WIDTH-1:0]    out_window,
    output logic [D_CNT_WIDTH-1:0]       out_cnt,
    output logic                         out_window_valid,
    output logic                         out_eos,
    output logic                         out_error,
`ifdef DEC_REFILL_BYTE_COUNT_EN
    output logic [31:0]                  out_byte_count,
`endif
    output logic [1:0]                   out_state
);

    state_t                      state_q, state_d;
    logic [D_WINDOW_WIDTH-1:0]   window_q, window_d;
    logic [D_CNT_WIDTH-1:0]      cnt_q, cnt_d;
    logic                        error_q, error_d;

    logic                        run_like;
    logic                        amt_ok;
    logic                        illegal_shift;
    logic                        shift_en;
    logic                        byte_acc;
    logic [D_WINDOW_WIDTH-1:0]   sh_window;
    logic [D_CNT_WIDTH-1:0]      sh_cnt;

    assign run_like         = (state_q == ST_FILL) || (state_q == ST_RUN);
    assign in_byte_ready    = run_like && (cnt_q <= CNT_READY_MAX);
    assign out_window_valid = (state_q == ST_RUN) || (state_q == ST_EOS);
    assign out_eos          = (state_q == ST_EOS);
    assign out_error        = error_q;
    assign out_window       = window_q;
    assign out_cnt          = cnt_q;
    assign out_state        = state_q;

    assign byte_acc      = in_byte_valid && in_byte_ready;
    assign amt_ok        = (in_shift_amount <= SHIFT_MAX);
    // A shift that would underflow the window, or comes before the window is valid.
    assign illegal_shift = run_like && in_shift_valid &&
                           (!amt_ok || (D_CNT_WIDTH'(in_shift_amount) > cnt_q) || !out_window_valid);
    assign shift_en      = !in_flag_first && in_shift_valid &&
                           ((run_like && !illegal_shift) || ((state_q == ST_EOS) && amt_ok));

    dec_window_shifter u_shifter (
        .window_i    (window_q),
        .cnt_i       (cnt_q),
        .shift_en_i  (shift_en),
        .shift_amt_i (in_shift_amount),
        .insert_en_i (byte_acc),
        .byte_i      (in_byte),
        .window_o    (sh_window),
        .cnt_o       (sh_cnt)
    );

    // State, window, count and sticky error registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            window_q <= WINDOW_ONES;
            cnt_q    <= '0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            window_q <= window_d;
            cnt_q    <= cnt_d;
            error_q  <= error_d;
        end
    end

    // Next-state logic; stream restart outranks any shift or byte this cycle.
    always_comb begin
        state_d  = state_q;
        window_d = window_q;
        cnt_d    = cnt_q;
        error_d  = error_q;
        if (in_flag_first) begin
            state_d  = ST_FILL;
            window_d = WINDOW_ONES;
            cnt_d    = '0;
            error_d  = 1'b0;
        end else begin
            case (state_q)
                ST_FILL, ST_RUN: begin
                    window_d = sh_window;
                    cnt_d    = sh_cnt;
                    if (illegal_shift) begin
                        error_d = 1'b1;
                    end
                    if (byte_acc && in_byte_last) begin
                        state_d = ST_EOS;
                        cnt_d   = CNT_FULL;
                    end else begin
                        state_d = (sh_cnt >= CNT_MIN_VALID) ? ST_RUN : ST_FILL;
                    end
                end
                ST_EOS: begin
                    // Padding past the end is infinite ones, so the window stays full.
                    window_d = sh_window;
                    cnt_d    = CNT_FULL;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

`ifdef DEC_REFILL_BYTE_COUNT_EN
    logic [31:0] byte_count_q, byte_count_d;

    assign out_byte_count = byte_count_q;

    // Saturating count of accepted bytes since the stream started.
    always_comb begin
        byte_count_d = byte_count_q;
        if (in_flag_first) begin
            byte_count_d = '0;
        end else if (byte_acc && (byte_count_q != 32'hFFFF_FFFF)) begin
            byte_count_d = byte_count_q + 32'd1;
        end
    end

    // Byte counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            byte_count_q <= '0;
        end else begin
            byte_count_q <= byte_count_d;
        end
    end
`endif

endmodule

// File: tb/tb_dec_bit_refill.sv
// Directed testbench for dec_bit_refill: hand-computed window/count/flag
// expectations for fill, shift, combined shift+insert, full window, EOS,
// illegal shifts and restart priority.
module tb_dec_bit_refill;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_flag_first;
    logic [7:0]  in_byte;
    logic        in_byte_valid;
    logic        in_byte_last;
    logic        in_byte_ready;
    logic        in_shift_valid;
    logic [4:0]  in_shift_amount;
    logic [31:0] out_window;
    logic [5:0]  out_cnt;
    logic        out_window_valid;
    logic        out_eos;
    logic        out_error;
    logic [1:0]  out_state;
`ifdef DEC_REFILL_BYTE_COUNT_EN
    logic [31:0] out_byte_count;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    dec_bit_refill dut (
        .clk              (clk),
        .reset            (reset),
        .in_flag_first    (in_flag_first),
        .in_byte          (in_byte),
        .in_byte_valid    (in_byte_valid),
        .in_byte_last     (in_byte_last),
        .in_byte_ready    (in_byte_ready),
        .in_shift_valid   (in_shift_valid),
        .in_shift_amount  (in_shift_amount),
        .out_window       (out_window),
        .out_cnt          (out_cnt),
        .out_window_valid (out_window_valid),
        .out_eos          (out_eos),
        .out_error        (out_error),
`ifdef DEC_REFILL_BYTE_COUNT_EN
        .out_byte_count   (out_byte_count),
`endif
        .out_state        (out_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Drive one cycle of inputs, let the edge pass, then return to idle inputs.
    task automatic drive(input logic first, input logic bv, input logic [7:0] b,
                         input logic last, input logic sv, input logic [4:0] d);
        in_flag_first   = first;
        in_byte_valid   = bv;
        in_byte         = b;
        in_byte_last    = last;
        in_shift_valid  = sv;
        in_shift_amount = d;
        @(posedge clk);
        #1;
        in_flag_first   = 1'b0;
        in_byte_valid   = 1'b0;
        in_byte         = 8'h00;
        in_byte_last    = 1'b0;
        in_shift_valid  = 1'b0;
        in_shift_amount = 5'd0;
    endtask

    task automatic start_case1();
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0);
        drive(1'b0, 1'b1, 8'h12, 1'b0, 1'b0, 5'd0);
        drive(1'b0, 1'b1, 8'h34, 1'b0, 1'b0, 5'd0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_flag_first = 1'b0; in_byte_valid = 1'b0; in_byte = 8'h00;
        in_byte_last = 1'b0; in_shift_valid = 1'b0; in_shift_amount = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        tests_run++;
        if (out_window !== 32'hFFFF_FFFF || out_cnt !== 6'd0 || in_byte_ready !== 1'b0 ||
            out_window_valid !== 1'b0 || out_eos !== 1'b0 || out_error !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset: win=%h cnt=%0d rdy=%b vld=%b eos=%b err=%b, want FFFFFFFF 0 0 0 0 0",
                     out_window, out_cnt, in_byte_ready, out_window_valid, out_eos, out_error);
        end
        // Shifts in IDLE are ignored without error.
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 5'd4);
        tests_run++;
        if (out_window !== 32'hFFFF_FFFF || out_cnt !== 6'd0 || out_error !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_shift: win=%h cnt=%0d err=%b, want FFFFFFFF 0 0",
                     out_window, out_cnt, out_error);
        end
    endtask

    task automatic test_fill();
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0);
        tests_run++;
        if (in_byte_ready !== 1'b1 || out_window_valid !== 1'b0 || out_cnt !== 6'd0) begin
            tests_failed++;
            $display("FAIL first: rdy=%b vld=%b cnt=%0d, want 1 0 0", in_byte_ready, out_window_valid, out_cnt);
        end
        drive(1'b0, 1'b1, 8'h12, 1'b0, 1'b0, 5'd0);
        tests_run++;
        if (out_window !== 32'hEDFF_FFFF || out_cnt !== 6'd8 || out_window_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL fill_byte1: win=%h cnt=%0d vld=%b, want EDFFFFFF 8 0",
                     out_window, out_cnt, out_window_valid);
        end
        drive(1'b0, 1'b1, 8'h34, 1'b0, 1'b0, 5'd0);
        tests_run++;
        if (out_window !== 32'hEDCB_FFFF || out_cnt !== 6'd16 || out_window_valid !== 1'b1 ||
            in_byte_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL fill_byte2: win=%h cnt=%0d vld=%b rdy=%b, want EDCBFFFF 16 1 1",
                     out_window, out_cnt, out_window_valid, in_byte_ready);
        end
    endtask

    task automatic test_shift();
        start_case1();
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 5'd4);
        tests_run++;
        if (out_window !== 32'hDCBF_FFFF || out_cnt !== 6'd12 || out_window_valid !== 1'b0 ||
            out_error !== 1'b0) begin
            tests_failed++;
            $display("FAIL shift4: win=%h cnt=%0d vld=%b err=%b, want DCBFFFFF 12 0 0",
                     out_window, out_cnt, out_window_valid, out_error);
        end
        // Shift by the full count drains the window back to all ones.
        start_case1();
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 5'd16);
        tests_run++;
        if (out_window !== 32'hFFFF_FFFF || out_cnt !== 6'd0 || out_error !== 1'b0 ||
            out_window_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL shift16: win=%h cnt=%0d err=%b vld=%b, want FFFFFFFF 0 0 0",
                     out_window, out_cnt, out_error, out_window_valid);
        end
    endtask

    task automatic test_shift_and_byte();
        start_case1();
        drive(1'b0, 1'b1, 8'h56, 1'b0, 1'b1, 5'd4);
        tests_run++;
        if (out_window !== 32'hDCBA_9FFF || out_cnt !== 6'd20 || out_window_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL shift_byte: win=%h cnt=%0d vld=%b, want DCBA9FFF 20 1",
                     out_window, out_cnt, out_window_valid);
        end
    endtask

    task automatic test_full();
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 5'd0);
        tests_run++;
        if (out_window !== 32'hFFFF_FFFF || out_cnt !== 6'd32 || in_byte_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL full: win=%h cnt=%0d rdy=%b, want FFFFFFFF 32 0",
                     out_window, out_cnt, in_byte_ready);
        end
        // Offered byte must not be taken while full.
        drive(1'b0, 1'b1, 8'h77, 1'b0, 1'b0, 5'd0);
        tests_run++;
        if (out_window !== 32'hFFFF_FFFF || out_cnt !== 6'd32) begin
            tests_failed++;
            $display("FAIL full_hold: win=%h cnt=%0d, want FFFFFFFF 32", out_window, out_cnt);
        end
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 5'd8);
        tests_run++;
        if (out_cnt !== 6'd24 || in_byte_ready !== 1'b1 || out_window !== 32'hFFFF_FFFF) begin
            tests_failed++;
            $display("FAIL full_drain: cnt=%0d rdy=%b win=%h, want 24 1 FFFFFFFF",
                     out_cnt, in_byte_ready, out_window);
        end
    endtask

    task automatic test_eos();
        start_case1();
        drive(1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 5'd0);
        tests_run++;
        if (out_eos !== 1'b1 || in_byte_ready !== 1'b0 || out_cnt !== 6'd32 ||
            out_window !== 32'hEDCB_5AFF || out_window_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL eos: eos=%b rdy=%b cnt=%0d win=%h vld=%b, want 1 0 32 EDCB5AFF 1",
                     out_eos, in_byte_ready, out_cnt, out_window, out_window_valid);
        end
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 5'd16);
        tests_run++;
        if (out_window !== 32'h5AFF_FFFF || out_cnt !== 6'd32 || out_window_valid !== 1'b1 ||
            out_eos !== 1'b1) begin
            tests_failed++;
            $display("FAIL eos_shift: win=%h cnt=%0d vld=%b eos=%b, want 5AFFFFFF 32 1 1",
                     out_window, out_cnt, out_window_valid, out_eos);
        end
    endtask

    task automatic test_error();
        start_case1();
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 5'd17);
        tests_run++;
        if (out_error !== 1'b1 || out_window !== 32'hEDCB_FFFF || out_cnt !== 6'd16) begin
            tests_failed++;
            $display("FAIL shift17: err=%b win=%h cnt=%0d, want 1 EDCBFFFF 16",
                     out_error, out_window, out_cnt);
        end
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0);
        tests_run++;
        if (out_error !== 1'b0 || out_window !== 32'hFFFF_FFFF || out_cnt !== 6'd0) begin
            tests_failed++;
            $display("FAIL err_clear: err=%b win=%h cnt=%0d, want 0 FFFFFFFF 0",
                     out_error, out_window, out_cnt);
        end
        // Illegal shift with a byte: byte still lands at c' = cnt.
        drive(1'b0, 1'b1, 8'h12, 1'b0, 1'b0, 5'd0);
        drive(1'b0, 1'b1, 8'h34, 1'b0, 1'b0, 5'd0);
        drive(1'b0, 1'b1, 8'h56, 1'b0, 1'b1, 5'd17);
        tests_run++;
        if (out_error !== 1'b1 || out_window !== 32'hEDCB_A9FF || out_cnt !== 6'd24) begin
            tests_failed++;
            $display("FAIL err_byte: err=%b win=%h cnt=%0d, want 1 EDCBA9FF 24",
                     out_error, out_window, out_cnt);
        end
        // Shift while still filling is illegal.
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0);
        drive(1'b0, 1'b1, 8'h12, 1'b0, 1'b0, 5'd0);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 5'd4);
        tests_run++;
        if (out_error !== 1'b1 || out_window !== 32'hEDFF_FFFF || out_cnt !== 6'd8) begin
            tests_failed++;
            $display("FAIL err_fill: err=%b win=%h cnt=%0d, want 1 EDFFFFFF 8",
                     out_error, out_window, out_cnt);
        end
    endtask

    task automatic test_restart_priority();
        start_case1();
        drive(1'b1, 1'b1, 8'h56, 1'b1, 1'b1, 5'd4);
        tests_run++;
        if (out_window !== 32'hFFFF_FFFF || out_cnt !== 6'd0 || out_eos !== 1'b0 ||
            out_window_valid !== 1'b0 || in_byte_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL restart: win=%h cnt=%0d eos=%b vld=%b rdy=%b, want FFFFFFFF 0 0 0 1",
                     out_window, out_cnt, out_eos, out_window_valid, in_byte_ready);
        end
`ifdef DEC_REFILL_BYTE_COUNT_EN
        drive(1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 5'd0);
        drive(1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 5'd0);
        tests_run++;
        if (out_byte_count !== 32'd2) begin
            tests_failed++;
            $display("FAIL byte_count: got %0d, want 2", out_byte_count);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_fill();
        test_shift();
        test_shift_and_byte();
        test_full();
        test_eos();
        test_error();
        test_restart_priority();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/dec_bit_refill.md
Name: dec_bit_refill

Overview:
Bitstream refill front end for the AV1 entropy decoder. It is the decode-side counterpart of the encoder's carry-propagation output stage. It accepts the byte stream the encoder emits, one byte per cycle with a valid/ready handshake. It maintains a left-aligned, inverted "dif" window, and the decoder core consumes that window by issuing per-symbol normalization shifts.

Parameters:
D_WINDOW_WIDTH, 32, width W of the dif window register.
D_CNT_WIDTH, 6, width of the valid-bit counter; must hold 0..W.
D_SIZE, 5, width of the shift-amount input (max legal shift 16).
D_BITSTREAM_WIDTH, 8, input byte width.
D_MIN_VALID, 16, minimum valid bits required for out_window_valid.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_flag_first  in  1  one-cycle pulse; starts (or restarts) a stream
in_byte  in  D_BITSTREAM_WIDTH  next bitstream byte
in_byte_valid  in  1  in_byte is valid
in_byte_last  in  1  qualifies in_byte as the final byte of the stream
in_byte_ready  out  1  block accepts in_byte this cycle
in_shift_valid  in  1  decoder core requests a normalization shift
in_shift_amount  in  D_SIZE  shift d (0..16)
out_window  out  D_WINDOW_WIDTH  dif window; valid bits occupy the MSBs
out_cnt  out  D_CNT_WIDTH  number of valid bits in out_window
out_window_valid  out  1  window is safe to decode from
out_eos  out  1  last byte has been accepted
out_error  out  1  sticky underflow / illegal shift

Behaviour:
- Reset is synchronous and active-high; there is one clock, clk.
- Reset values:
  - window = all ones; cnt = 0; state = IDLE.
  - in_byte_ready = 0, out_window_valid = 0, out_eos = 0, out_error = 0.
- Window convention:
  - Vacant bits are always 1.
  - A byte is inserted by XORing the zero-extended byte at bits [W-1-c' : W-8-c'], which stores ~byte.
  - A shift by d is window = (window << d) | ((1<<d)-1), so ones are shifted in.
- States:
  - IDLE: in_flag_first -> FILL (window = all ones, cnt = 0, error = 0). Shifts are ignored and do not flag an error.
  - FILL: cnt >= D_MIN_VALID -> RUN.
  - RUN: cnt < D_MIN_VALID -> FILL.
  - FILL/RUN: accepting a byte with in_byte_last -> EOS.
  - EOS: cnt is forced to W, since padding is infinite ones. in_byte_ready = 0, out_window_valid = 1, out_eos = 1. Only in_flag_first or reset leaves EOS.
  - in_flag_first in any state restarts the stream as in IDLE -> FILL. It has priority over a shift or byte in the same cycle, and both of those are dropped.
- Handshake:
  - in_byte_ready = (state is FILL or RUN) and (cnt <= W-8). It is derived from registers only, with no combinational path from in_shift_*.
  - A byte is accepted when in_byte_valid and in_byte_ready are both high at a clock edge.
- out_window_valid = (state == RUN) or (state == EOS); this is equivalent to cnt >= D_MIN_VALID outside IDLE.
- Same-cycle event order: the shift applies first, then the insert.
  - c' = cnt - d (d = 0 when no shift).
  - New cnt = c' + 8 if a byte is accepted, otherwise c'.
- Illegal shift: in FILL/RUN with in_shift_valid and (d > 16, or d > cnt, or !out_window_valid).
  - Set out_error (sticky until in_flag_first or reset).
  - Leave window and cnt unchanged.
  - A byte accepted in the same cycle is still inserted at c' = cnt.
- Latency: an accepted byte or shift is visible on out_window/out_cnt the cycle after the edge. All outputs are registered or decoded from registers.
- Full window: cnt = W (or > W-8) -> ready = 0 until shifts free at least 8 bits.

Optional Feature:
DEC_REFILL_BYTE_COUNT_EN:
- Defined: adds output out_byte_count (32 bits).
  - Counts accepted bytes since in_flag_first.
  - Cleared by reset and by in_flag_first.
  - Saturates at 0xFFFFFFFF.
  - Used to compute the decoder tell() position.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Decomposition:
- Shared package dec_refill_pkg holds:
  - state encoding localparams (IDLE, FILL, RUN, EOS);
  - D_MIN_VALID;
  - maximum shift (16);
  - all-ones window constant.
- One natural sub-module, dec_window_shifter. It is combinational shift-with-ones plus byte XOR-insert at computed offset c'. It is reused by the decoder's multi-symbol path.

Test Plan:
1. Reset, in_flag_first, bytes 0x12, 0x34 -> out_window = 0xEDCBFFFF, out_cnt = 16, out_window_valid = 1 two cycles after the first byte is accepted.
2. From case 1, shift d = 4 alone -> window = 0xDCBFFFFF, cnt = 12, valid = 0 (FILL).
3. From case 1, shift d = 4 and byte 0x56 in the same cycle -> window = 0xDCBA9FFF, cnt = 20.
4. Feed bytes 0x00 x4 with no shifts -> cnt = 32, window = 0xFFFFFFFF, in_byte_ready = 0. After a shift of 8 -> ready = 1, cnt = 24.
5. Byte 0xA5 with in_byte_last after case 1 -> out_eos = 1, ready = 0, cnt = 32. Then shift 16 -> window upper 16 = 0x5AFF, low bits all ones, valid stays 1.
6. cnt = 16, shift d = 17 -> out_error = 1, window/cnt unchanged. in_flag_first -> error = 0, window = all ones, cnt = 0.
